// File: rtl/freq_divider_multi_if.sv
// Control and output bundle for the multi-channel clock divider.
// The master side drives enables, modes, sync and divide values; the slave side
// (the divider) returns the divided clocks and terminal-count strobes.
interface freq_divider_multi_if #(
   parameter int unsigned CNT_W = 12,
   parameter int unsigned N_CH  = 4
);
   logic [N_CH-1:0]       enable;
   logic [N_CH-1:0]       mode;
   logic                  sync;
   logic [N_CH*CNT_W-1:0] div_value;
   logic [N_CH-1:0]       div_out;
   logic [N_CH-1:0]       tick;

   modport master (
      output enable,
      output mode,
      output sync,
      output div_value,
      input  div_out,
      input  tick
   );

   modport slave (
      input  enable,
      input  mode,
      input  sync,
      input  div_value,
      output div_out,
      output tick
   );
endinterface

// File: rtl/freq_divider_multi.sv
// Multi-channel programmable clock divider feeding the DPWM counters.
// Each channel counts 0..D and emits a one-cycle tick at the terminal count.
// Toggle mode (mode=0) flips div_out on every tick for a 50% duty clock of period
// 2*(D+1); pulse mode (mode=1) makes div_out a copy of the tick strobe.
// The divide value is shadowed into div_q only while the counter restarts, so a
// change on div_value never shortens or stretches the period in progress.
module freq_divider_multi #(
   parameter int unsigned CNT_W = 12,
   parameter int unsigned N_CH  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   freq_divider_multi_if.slave   bus
);

   logic [CNT_W-1:0] cnt_q [N_CH];
   logic [CNT_W-1:0] div_q [N_CH];
   logic [N_CH-1:0]  div_out_q;
   logic [N_CH-1:0]  tick_q;

   // Per-channel counter, shadow divide value and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < int'(N_CH); i++) begin
            cnt_q[i] <= '0;
            div_q[i] <= '0;
         end
         div_out_q <= '0;
         tick_q    <= '0;
      end else begin
         for (int i = 0; i < int'(N_CH); i++) begin
            if (!bus.enable[i] || bus.sync) begin
               // Idle or phase-align: park at count 0 and keep tracking div_value,
               // so the next period starts with the current divide value.
               // sync wins over a coincident terminal count, suppressing its tick.
               cnt_q[i]     <= '0;
               div_q[i]     <= bus.div_value[i*CNT_W +: CNT_W];
               div_out_q[i] <= 1'b0;
               tick_q[i]    <= 1'b0;
            end else if (cnt_q[i] == div_q[i]) begin
               // Terminal count: restart the period and reload the shadow value.
               cnt_q[i]     <= '0;
               div_q[i]     <= bus.div_value[i*CNT_W +: CNT_W];
               tick_q[i]    <= 1'b1;
               div_out_q[i] <= bus.mode[i] ? 1'b1 : ~div_out_q[i];
            end else begin
               // cnt stays below div_q here, so the increment cannot wrap.
               cnt_q[i]  <= cnt_q[i] + CNT_W'(1);
               tick_q[i] <= 1'b0;
               if (bus.mode[i]) begin
                  div_out_q[i] <= 1'b0;
               end
            end
         end
      end
   end

   assign bus.div_out = div_out_q;
   assign bus.tick    = tick_q;

endmodule

// File: tb/tb_freq_divider_multi.sv
// Directed bench for freq_divider_multi. Expected tick/div_out values are queued
// as each step is driven and checked just after the following rising edge.
module tb_freq_divider_multi;

   localparam int unsigned CNT_W = 12;
   localparam int unsigned N_CH  = 4;

   typedef struct {
      string tag;
      int    ch;
      logic  t;
      logic  d;
   } exp_t;

   logic clk;
   logic reset;
   int   errors;
   int   checks;
   exp_t sb[$];

   freq_divider_multi_if #(.CNT_W(CNT_W), .N_CH(N_CH)) bus ();

   freq_divider_multi #(.CNT_W(CNT_W), .N_CH(N_CH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // tick after the j-th edge (j=0 is the first enabled edge with cnt=0)
   function automatic logic f_tick(int d, int j);
      return ((j + 1) % (d + 1)) == 0;
   endfunction

   function automatic logic f_div(int d, bit m, int j);
      if (m) return f_tick(d, j);
      return (((j + 1) / (d + 1)) % 2) == 1;
   endfunction

   task automatic push(string tag, int ch, logic t, logic d);
      exp_t e;
      e.tag = tag;
      e.ch  = ch;
      e.t   = t;
      e.d   = d;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         assert (bus.tick[e.ch] === e.t) else begin
            errors++;
            $error("FAIL %s ch%0d tick observed=%b expected=%b", e.tag, e.ch, bus.tick[e.ch], e.t);
         end
         checks++;
         assert (bus.div_out[e.ch] === e.d) else begin
            errors++;
            $error("FAIL %s ch%0d div_out observed=%b expected=%b", e.tag, e.ch,
                   bus.div_out[e.ch], e.d);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      drain();
   endtask

   task automatic set_div(int ch, int d);
      bus.div_value[ch*CNT_W +: CNT_W] = d[CNT_W-1:0];
   endtask

   // Park a channel for one edge with the new D/mode loaded, then enable it.
   task automatic fresh(string tag, int ch, int d, bit m);
      bus.enable[ch] = 1'b0;
      set_div(ch, d);
      bus.mode[ch] = m;
      push(tag, ch, 1'b0, 1'b0);
      step();
      bus.enable[ch] = 1'b1;
   endtask

   task automatic run(string tag, int ch, int d, bit m, int j0, int n);
      for (int j = j0; j < j0 + n; j++) begin
         push(tag, ch, f_tick(d, j), f_div(d, m, j));
         step();
      end
   endtask

   initial begin
      int ntk;
      logic tk;
      errors        = 0;
      checks        = 0;
      reset         = 1'b1;
      bus.enable    = '0;
      bus.mode      = '0;
      bus.sync      = 1'b0;
      bus.div_value = '0;

      // Reset state
      @(posedge clk);
      for (int c = 0; c < int'(N_CH); c++) push("reset", c, 1'b0, 1'b0);
      step();
      reset = 1'b0;

      // Toggle mode, D=4: tick every 5, div_out period 10
      fresh("tog_d4_idle", 0, 4, 1'b0);
      run("tog_d4", 0, 4, 1'b0, 0, 25);

      // Pulse mode, D=2 on ch1
      bus.enable[0] = 1'b0;
      fresh("pul_d2_idle", 1, 2, 1'b1);
      run("pul_d2", 1, 2, 1'b1, 0, 9);

      // Pulse mode, D=0: both outputs constantly high
      fresh("pul_d0_idle", 1, 0, 1'b1);
      run("pul_d0", 1, 0, 1'b1, 0, 5);
      bus.enable[1] = 1'b0;

      // Shadow reload: D=9 changed to 3 when cnt=5
      fresh("reload_idle", 0, 9, 1'b0);
      run("reload_pre", 0, 9, 1'b0, 0, 5);
      set_div(0, 3);
      ntk = 0;
      for (int j = 5; j < 23; j++) begin
         tk = (j == 9) || (j > 9 && ((j - 9) % 4) == 0);
         if (tk) ntk++;
         push("reload", 0, tk, ntk[0]);
         step();
      end

      // Sync alignment of ch0 and ch2 (D=7) enabled 3 clocks apart
      bus.enable = '0;
      set_div(0, 7);
      set_div(2, 7);
      bus.mode = '0;
      push("sync_idle", 0, 1'b0, 1'b0);
      push("sync_idle", 2, 1'b0, 1'b0);
      step();
      bus.enable[0] = 1'b1;
      run("sync_pre0", 0, 7, 1'b0, 0, 3);
      bus.enable[2] = 1'b1;
      for (int j = 3; j < 5; j++) begin
         push("sync_pre0", 0, f_tick(7, j), f_div(7, 1'b0, j));
         push("sync_pre2", 2, f_tick(7, j - 3), f_div(7, 1'b0, j - 3));
         step();
      end
      bus.sync = 1'b1;
      push("sync_clear", 0, 1'b0, 1'b0);
      push("sync_clear", 2, 1'b0, 1'b0);
      step();
      bus.sync = 1'b0;
      for (int j = 0; j < 23; j++) begin
         push("sync_aligned", 0, f_tick(7, j), f_div(7, 1'b0, j));
         push("sync_aligned", 2, f_tick(7, j), f_div(7, 1'b0, j));
         step();
      end
      // j=23 would be a terminal edge; sync must suppress the tick
      bus.sync = 1'b1;
      push("sync_on_tc", 0, 1'b0, 1'b0);
      push("sync_on_tc", 2, 1'b0, 1'b0);
      step();
      bus.sync = 1'b0;
      for (int j = 0; j < 8; j++) begin
         push("sync_after_tc", 0, f_tick(7, j), f_div(7, 1'b0, j));
         push("sync_after_tc", 2, f_tick(7, j), f_div(7, 1'b0, j));
         step();
      end
      bus.enable = '0;

      // Full-scale divide value: period 4096, no wrap
      fresh("max_idle", 3, 4095, 1'b1);
      run("max_d4095", 3, 4095, 1'b1, 0, 8194);

      // D=0 toggle: div_out alternates every clock
      fresh("tog_d0_idle", 3, 0, 1'b0);
      run("tog_d0", 3, 0, 1'b0, 0, 8);
      bus.enable[3] = 1'b0;

      // Asynchronous reset mid-period
      fresh("rst_idle", 0, 4, 1'b0);
      run("rst_pre", 0, 4, 1'b0, 0, 7);
      #3;
      reset = 1'b1;
      #1;
      push("rst_async", 0, 1'b0, 1'b0);
      drain();
      bus.enable[0] = 1'b0;
      step();
      push("rst_held", 0, 1'b0, 1'b0);
      step();
      reset = 1'b0;
      fresh("rst_release", 0, 4, 1'b0);
      run("rst_reenable", 0, 4, 1'b0, 0, 10);

      // Enable dropped mid-period clears at the next edge
      bus.enable[0] = 1'b0;
      push("en_drop", 0, 1'b0, 1'b0);
      step();
      bus.enable[0] = 1'b1;
      run("en_reenable", 0, 4, 1'b0, 0, 7);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
